ysyx_2022040010_wb_arb: RTL and testbench
=========================================

Name: ysyx_2022040010_wb_arb

Overview:
- Arbitrates the single register-file write port between the in-order writeback stage and the long-latency multiply/divide unit (MDU).
- Pipeline writes have priority. MDU results queue in a small FIFO and drain into idle write slots.
- If the FIFO starves, the block raises a one-cycle stall request so that the pipeline's writeback stage presents a bubble and the FIFO head drains.
- Sits between the WB stage, the MDU and the regfile. It also exports a pending-destination mask for the ID-stage scoreboard.

Parameters:
- XLEN, 64, data width.
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive no-drain cycles with a non-empty FIFO before a forced drain.
- CNT_W, 3, starvation counter width (must hold STARVE_LIMIT).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  WB-stage write enable
- pipe_waddr  in  5  WB-stage destination register
- pipe_wdata  in  XLEN  WB-stage write data
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  FIFO can accept
- mdu_waddr  in  5  MDU destination register
- mdu_wdata  in  XLEN  MDU result
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  5  regfile write address (registered)
- rf_wdata  out  XLEN  regfile write data (registered)
- rf_src  out  1  0 = pipe, 1 = MDU (registered)
- stall_req  out  1  request that the pipeline hold WB (stall[3])
- pend_mask  out  32  bit i = MDU result for x_i queued
- fifo_cnt  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: rf_we, rf_waddr, rf_wdata and rf_src = 0; stall_req = 0; FIFO emptied; fifo_cnt = 0; pend_mask = 0; starvation counter = 0; state IDLE. Reset mid-operation discards queued MDU results without writing them.
- Effective pipe write: pipe_eff = pipe_we & (pipe_waddr != 0) & (state != FORCE). In FORCE, pipe inputs are ignored; the stalled WB stage presents a bubble.
- Pop: pop = (fifo_cnt != 0) & (!pipe_eff | state == FORCE).
- Write port, registered, one-cycle latency:
  - pipe_eff → rf_* = pipe fields, rf_src = 0.
  - else pop → rf_* = FIFO head, rf_src = 1.
  - else rf_we = 0; rf_waddr/rf_wdata hold their last value.
- x0: writes to x0 are never issued. A pipe write to x0 is treated as idle. An MDU result for x0 is accepted but not pushed.
- mdu_ready = (fifo_cnt < DEPTH). It is based on registered occupancy only; there is no same-cycle pass-through when full.
- Push: on mdu_valid & mdu_ready. No bypass: minimum MDU latency is push at N, pop at N+1, rf_we at N+2.
- Simultaneous push and pop: occupancy is unchanged. Order is strictly FIFO; pointers wrap modulo DEPTH.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and pop = 0.
  - Clears on pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- States:
  - IDLE (FIFO empty) → PEND on a push.
  - PEND → IDLE when the FIFO becomes empty.
  - PEND → FORCE when the counter reaches STARVE_LIMIT; this is registered, so FORCE is entered the following cycle.
  - FORCE: stall_req = 1 and the head is popped unconditionally. Next state is PEND if entries remain, else IDLE; the counter restarts from 0.
  - stall_req = (state == FORCE), so it is a one-cycle pulse per forced drain.
  - A push during FORCE is allowed.
- pend_mask: OR of one-hot(waddr) over valid FIFO entries. An entry clears the cycle after its pop; bit 0 is always 0. It is combinational from registered FIFO state.
- Ordering guarantee (interface contract): the scoreboard, using pend_mask, never issues a pipe write to a register with a pending MDU result. The block does not check for this.

Test Plan:
- Pipe write: after reset, pipe_we=1, waddr=5, wdata=0x1234 at cycle N → at N+1 rf_we=1, rf_waddr=5, rf_wdata=0x1234, rf_src=0. Then pipe_we=0 → rf_we=0 at N+2.
- x0 dropped: pipe_we=1, waddr=0; and MDU push with waddr=0 → rf_we stays 0, fifo_cnt stays 0, pend_mask=0.
- MDU idle-slot drain: pipe idle, mdu_valid, waddr=7, wdata=0xAA at N → pend_mask[7]=1 at N+1. At N+2 rf_we=1, waddr=7, data=0xAA, rf_src=1. pend_mask=0 at N+2.
- Full and starvation: pipe writes every cycle; MDU pushes x3 then x4 → fifo_cnt=2, mdu_ready=0. stall_req pulses for exactly one cycle, STARVE_LIMIT+1 cycles after the first push, and x3 is written the following cycle with rf_src=1 while the pipe write that cycle is ignored. x4 is force-drained STARVE_LIMIT+1 cycles later.
- Simultaneous push/pop: fifo_cnt=1, pipe idle, new MDU push in the same cycle → head written next cycle, fifo_cnt stays 1, new entry popped the following cycle (FIFO order).
- Reset mid-FORCE: assert rst while stall_req=1 and fifo_cnt=2 → next cycle stall_req=0, fifo_cnt=0, pend_mask=0, rf_we=0, mdu_ready=1; no queued result is ever written.

Source files
------------

// File: rtl/ysyx_2022040010_wb_arb_if.sv
// Signal bundle between the WB stage / MDU (master side) and the regfile write-port arbiter (slave side).
interface ysyx_2022040010_wb_arb_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            pipe_we;
    logic [4:0]      pipe_waddr;
    logic [XLEN-1:0] pipe_wdata;
    logic            mdu_valid;
    logic            mdu_ready;
    logic [4:0]      mdu_waddr;
    logic [XLEN-1:0] mdu_wdata;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            rf_src;
    logic            stall_req;
    logic [31:0]     pend_mask;
    logic [CW-1:0]   fifo_cnt;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata, mdu_valid, mdu_waddr, mdu_wdata,
        input  mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, pend_mask, fifo_cnt
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata, mdu_valid, mdu_waddr, mdu_wdata,
        output mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, pend_mask, fifo_cnt
    );
endinterface

// File: rtl/ysyx_2022040010_wb_arb.sv
// Regfile write-port arbiter: pipeline writes win, MDU results queue in a FIFO and drain into idle slots,
// with a one-cycle forced drain (stall_req) when the FIFO starves.
module ysyx_2022040010_wb_arb #(
    parameter int XLEN         = 64,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_2022040010_wb_arb_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_FORCE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [DEPTH-1:0] r_vld;
    logic [4:0]       r_fifo_addr [DEPTH];
    logic [XLEN-1:0]  r_fifo_data [DEPTH];
    logic [CNT_W-1:0] r_starve, w_starve_nxt;
    logic             r_rf_we, r_rf_src;
    logic [4:0]       r_rf_waddr;
    logic [XLEN-1:0]  r_rf_wdata;
    logic             w_pipe_eff, w_pop, w_push, w_ready;
    logic [31:0]      w_pend;

    // In FORCE the WB stage is stalled, so whatever it presents is a bubble.
    assign w_pipe_eff = bus.pipe_we && (bus.pipe_waddr != 5'd0) && (r_state != S_FORCE);
    assign w_pop      = (r_cnt != '0) && (!w_pipe_eff || (r_state == S_FORCE));
    assign w_ready    = (r_cnt < CW'(DEPTH));
    assign w_push     = bus.mdu_valid && w_ready && (bus.mdu_waddr != 5'd0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + CW'(1);
        else if (!w_push && w_pop)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    always_comb begin
        w_starve_nxt = '0;
        if ((r_cnt != '0) && !w_pop)
            w_starve_nxt = (r_starve == CNT_W'(STARVE_LIMIT)) ? r_starve : r_starve + CNT_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_push) w_state_nxt = S_PEND;
            S_PEND: begin
                if (w_cnt_nxt == '0)
                    w_state_nxt = S_IDLE;
                else if (w_starve_nxt == CNT_W'(STARVE_LIMIT))
                    w_state_nxt = S_FORCE;
            end
            S_FORCE: w_state_nxt = (w_cnt_nxt != '0) ? S_PEND : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_vld    <= '0;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_starve <= w_starve_nxt;
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: payload storage is not reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.mdu_waddr;
            r_fifo_data[r_wr_ptr] <= bus.mdu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_rf_src   <= 1'b0;
        end else if (w_pipe_eff) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= bus.pipe_waddr;
            r_rf_wdata <= bus.pipe_wdata;
            r_rf_src   <= 1'b0;
        end else if (w_pop) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= r_fifo_addr[r_rd_ptr];
            r_rf_wdata <= r_fifo_data[r_rd_ptr];
            r_rf_src   <= 1'b1;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++)
            if (r_vld[i]) w_pend[r_fifo_addr[i]] = 1'b1;
        w_pend[0] = 1'b0;
    end

    assign bus.mdu_ready = w_ready;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.rf_src    = r_rf_src;
    assign bus.stall_req = (r_state == S_FORCE);
    assign bus.pend_mask = w_pend;
    assign bus.fifo_cnt  = r_cnt;
endmodule

// File: tb/tb_ysyx_2022040010_wb_arb.sv
// Bench for the regfile write arbiter: directed vector table, hand-written starvation/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_ysyx_2022040010_wb_arb;
    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_2022040010_wb_arb_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    ysyx_2022040010_wb_arb #(
        .XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CNT_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        pwe;  logic [4:0] pa; logic [63:0] pd;
        logic        mv;   logic [4:0] ma; logic [63:0] md;
        logic        we;   logic [4:0] wa; logic [63:0] wd; logic src;
        logic        stall; logic [1:0] cnt; logic [31:0] pend; logic rdy;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    // Reference model: queue of pending MDU results plus the registered write-port view.
    ent_t        q[$];
    bit          m_force;
    int          m_starve;
    logic        m_we, m_src;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                           input logic src, input logic stall, input logic [1:0] cnt,
                           input logic [31:0] pend, input logic rdy);
        check({tag, ".rf_we"},     bus.rf_we,     we);
        check({tag, ".rf_waddr"},  bus.rf_waddr,  wa);
        check({tag, ".rf_wdata"},  bus.rf_wdata,  wd);
        if (we) check({tag, ".rf_src"}, bus.rf_src, src);
        check({tag, ".stall_req"}, bus.stall_req, stall);
        check({tag, ".fifo_cnt"},  bus.fifo_cnt,  cnt);
        check({tag, ".pend_mask"}, bus.pend_mask, pend);
        check({tag, ".mdu_ready"}, bus.mdu_ready, rdy);
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [63:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [63:0] md);
        bus.pipe_we    = pwe;
        bus.pipe_waddr = pa;
        bus.pipe_wdata = pd;
        bus.mdu_valid  = mv;
        bus.mdu_waddr  = ma;
        bus.mdu_wdata  = md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] m = '0;
        foreach (q[i]) m[q[i].a] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_step(input logic r, input logic pwe, input logic [4:0] pa, input logic [63:0] pd,
                              input logic mv, input logic [4:0] ma, input logic [63:0] md);
        bit pe, pop, rdy;
        int st;
        if (r) begin
            q.delete();
            m_force = 0; m_starve = 0;
            m_we = 0; m_wa = '0; m_wd = '0; m_src = 0;
            return;
        end
        pe  = pwe && (pa != 0) && !m_force;
        pop = (q.size() > 0) && !pe;
        rdy = q.size() < DEPTH;
        if (pe) begin
            m_we = 1; m_wa = pa; m_wd = pd; m_src = 0;
        end else if (pop) begin
            m_we = 1; m_wa = q[0].a; m_wd = q[0].d; m_src = 1;
        end else begin
            m_we = 0;
        end
        if (q.size() == 0 || pop) st = 0;
        else st = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        m_force  = !m_force && (st == LIMIT);
        m_starve = st;
        if (pop) void'(q.pop_front());
        if (mv && rdy && ma != 0) q.push_back('{ma, md});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        int   t;
        tbl[0]  = '{1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0,   1'b1, 5'd5,  64'h1234, 1'b0, 1'b0, 2'd0, 32'h0,    1'b1};
        tbl[1]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,   1'b0, 5'd5,  64'h1234, 1'b0, 1'b0, 2'd0, 32'h0,    1'b1};
        tbl[2]  = '{1'b1, 5'd0, 64'h99,   1'b1, 5'd0, 64'h55,  1'b0, 5'd5,  64'h1234, 1'b0, 1'b0, 2'd0, 32'h0,    1'b1};
        tbl[3]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,   1'b0, 5'd5,  64'h1234, 1'b0, 1'b0, 2'd0, 32'h0,    1'b1};
        tbl[4]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd7, 64'hAA,  1'b0, 5'd5,  64'h1234, 1'b0, 1'b0, 2'd1, 32'h80,   1'b1};
        tbl[5]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,   1'b1, 5'd7,  64'hAA,   1'b1, 1'b0, 2'd0, 32'h0,    1'b1};
        tbl[6]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd9, 64'h11,  1'b0, 5'd7,  64'hAA,   1'b0, 1'b0, 2'd1, 32'h200,  1'b1};
        tbl[7]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd10, 64'h22, 1'b1, 5'd9,  64'h11,   1'b1, 1'b0, 2'd1, 32'h400,  1'b1};
        tbl[8]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,   1'b1, 5'd10, 64'h22,   1'b1, 1'b0, 2'd0, 32'h0,    1'b1};
        tbl[9]  = '{1'b1, 5'd3, 64'h33,   1'b1, 5'd12, 64'h44, 1'b1, 5'd3,  64'h33,   1'b0, 1'b0, 2'd1, 32'h1000, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,   1'b1, 5'd12, 64'h44,   1'b1, 1'b0, 2'd0, 32'h0,    1'b1};

        // Reset state.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;

        // Directed vectors: pipe write, x0 drops, idle-slot drain, push/pop overlap, pipe priority.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].pwe, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].src,
                    tbl[i].stall, tbl[i].cnt, tbl[i].pend, tbl[i].rdy);
        end

        // Starvation: pipe writes every cycle, x3 and x4 pushed back-to-back; forced drains at cycles 5 and 10.
        for (int k = 0; k < 12; k++) begin
            int          c;
            logic [1:0]  ecnt;
            logic [31:0] epend;
            drive(1, 5'd20, 64'h1000 + 64'(k), k < 2, (k == 0) ? 5'd3 : 5'd4, (k == 0) ? 64'h300 : 64'h400);
            tick();
            c     = k + 1;
            ecnt  = (c == 1) ? 2'd1 : (c <= 5) ? 2'd2 : (c <= 10) ? 2'd1 : 2'd0;
            epend = (c == 1) ? 32'h8 : (c <= 5) ? 32'h18 : (c <= 10) ? 32'h10 : 32'h0;
            if (c == 6)
                chk_all($sformatf("starve%0d", c), 1, 5'd3, 64'h300, 1, 0, ecnt, epend, 1);
            else if (c == 11)
                chk_all($sformatf("starve%0d", c), 1, 5'd4, 64'h400, 1, 0, ecnt, epend, 1);
            else
                chk_all($sformatf("starve%0d", c), 1, 5'd20, 64'h1000 + 64'(k), 0,
                        (c == 5) || (c == 10), ecnt, epend, ecnt < 2);
        end

        // Reset while a forced drain is in progress with a full FIFO.
        drive(1, 5'd21, 64'h2000, 1, 5'd3, 64'h333);
        tick();
        drive(1, 5'd21, 64'h2001, 1, 5'd4, 64'h444);
        tick();
        drive(1, 5'd21, 64'h2002, 0, 5'd0, 64'h0);
        t = 0;
        while (!bus.stall_req && t < 20) begin
            tick();
            t++;
        end
        check("rstforce.stall_seen", bus.stall_req, 1);
        check("rstforce.cnt_full", bus.fifo_cnt, 2);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_all("rstforce", 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rstforce.nowrite%0d", i), bus.rf_we, 0);
        end

        // Randomized traffic against the reference model.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            logic        r, pwe, mv;
            logic [4:0]  pa, ma;
            logic [63:0] pd, md;
            chk_all("rand", m_we, m_wa, m_wd, m_src, m_force, 2'(q.size()), model_pend(), q.size() < DEPTH);
            r   = ($urandom_range(0, 199) == 0);
            pwe = ($urandom_range(0, 9) < 7);
            pa  = 5'($urandom_range(0, 31));
            pd  = {$urandom, $urandom};
            mv  = ($urandom_range(0, 9) < 4);
            ma  = 5'($urandom_range(0, 31));
            md  = {$urandom, $urandom};
            rst = r;
            drive(pwe, pa, pd, mv, ma, md);
            model_step(r, pwe, pa, pd, mv, ma, md);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
